// File: rtl/ram_fifo_pkg.sv
// Shared definitions for the RAM-backed FIFO controller.
// Holds default geometry and word/pointer types used by ram_fifo_ctrl and ram_fifo_skid.
package ram_fifo_pkg;

  localparam int unsigned DW_DEF = 64;
  localparam int unsigned AW_DEF = 12;

  typedef logic [DW_DEF-1:0] word_t;
  typedef logic [AW_DEF:0]   ptr_t;

endpackage

// File: rtl/ram_fifo_skid.sv
// Two-entry in-order output buffer that sits behind the RAM read port.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, data_i  capture a word into the tail
//   pop_i           consume the head word
//   data_o          head word (registered)
//   cnt_o           number of buffered words (0..2)
// The caller guarantees no push into a full buffer and no pop from an empty one.
module ram_fifo_skid #(
  parameter int unsigned DW = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic [1:0]    cnt_o
);

  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [1:0]    cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d = data_i;
        end else begin
          tail_d = data_i;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Shift and capture together; occupancy is unchanged.
        if (cnt_q == 2'd1) begin
          head_d = data_i;
        end else begin
          head_d = tail_q;
          tail_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o = head_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Streaming FIFO controller that turns an external dual-port RAM into FIFO storage.
// Push stream (s_*) drives the RAM write port; the RAM read port refills a 2-entry
// output buffer (ram_fifo_skid) that presents the pop stream (m_*).
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   s_valid, s_ready, s_data        push stream
//   m_valid, m_ready, m_data        pop stream
//   wr, wr_add, in                  RAM write port
//   rd, rd_add, out                 RAM read port (read data valid one cycle after rd)
//   full, empty                     status
// Optional feature macro RAM_FIFO_LEVEL_EN adds:
//   level        registered total occupancy (RAM + in flight + buffered)
//   almost_full  RAM-resident entries >= 2**AW-4
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          wr,
  output logic [AW-1:0] wr_add,
  output logic [DW-1:0] in,
  output logic          rd,
  output logic [AW-1:0] rd_add,
  input  logic [DW-1:0] out,
  output logic          full,
  output logic          empty
`ifdef RAM_FIFO_LEVEL_EN
  ,
  output logic [AW:0]   level,
  output logic          almost_full
`endif
);

  if (RD_LAT != 1) begin : g_bad_rd_lat
    $error("ram_fifo_ctrl supports RD_LAT == 1 only");
  end

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        rd_inflight_q;
  logic [1:0]  skid_cnt;
  logic        push, pop, ram_empty, rd_ok;
  logic [2:0]  credit_sum;

  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign s_ready   = !full;
  assign m_valid   = (skid_cnt != 2'd0);

  // Qualify RAM accesses with resetn so nothing reaches the RAM while reset is held.
  assign push = s_valid && s_ready && resetn;
  assign pop  = m_valid && m_ready;

  // Buffered + in-flight words after this edge's pop must leave room for one more.
  assign credit_sum = {1'b0, skid_cnt} + {2'b00, rd_inflight_q} - {2'b00, pop};
  assign rd_ok      = (credit_sum < 3'd2);

  assign wr     = push;
  assign wr_add = wr_ptr_q[AW-1:0];
  assign in     = resetn ? s_data : '0;
  assign rd     = !ram_empty && rd_ok && resetn;
  assign rd_add = rd_ptr_q[AW-1:0];

  assign empty = ram_empty && !rd_inflight_q && (skid_cnt == 2'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_inflight_q <= rd;
    end
  end

  ram_fifo_skid #(
    .DW (DW)
  ) u_skid (
    .clk_i  (clk),
    .rst_ni (resetn),
    .push_i (rd_inflight_q),
    .data_i (out),
    .pop_i  (pop),
    .data_o (m_data),
    .cnt_o  (skid_cnt)
  );

`ifdef RAM_FIFO_LEVEL_EN
  localparam logic [AW:0] AlmostFullThr = (AW+1)'((1 << AW) - 4);

  logic [AW:0] level_q, level_d;
  logic [AW:0] ram_cnt;
  logic [AW:0] skid_cnt_d;

  assign ram_cnt     = wr_ptr_q - rd_ptr_q;
  assign almost_full = (ram_cnt >= AlmostFullThr);

  // Level tracks the state after the edge, so it is computed from next-state values.
  always_comb begin
    skid_cnt_d = {{(AW-1){1'b0}}, skid_cnt} + {{AW{1'b0}}, rd_inflight_q} - {{AW{1'b0}}, pop};
    level_d    = (wr_ptr_d - rd_ptr_d) + {{AW{1'b0}}, rd} + skid_cnt_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level = level_q;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural 1-cycle-latency dual-port RAM.
// Expected pop words are queued when pushes are issued; a negedge monitor pops and compares.
module tb_ram_fifo_ctrl;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          resetn;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_data;
  logic          wr, rd;
  logic [AW-1:0] wr_add, rd_add;
  logic [DW-1:0] in;
  logic [DW-1:0] out = '0;
  logic          full, empty;
`ifdef RAM_FIFO_LEVEL_EN
  logic [AW:0]   level;
  logic          almost_full;
`endif

  always #5 clk = ~clk;

  ram_fifo_ctrl #(
    .DW     (DW),
    .AW     (AW),
    .RD_LAT (1)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .wr      (wr),
    .wr_add  (wr_add),
    .in      (in),
    .rd      (rd),
    .rd_add  (rd_add),
    .out     (out),
    .full    (full),
`ifdef RAM_FIFO_LEVEL_EN
    .level       (level),
    .almost_full (almost_full),
`endif
    .empty   (empty)
  );

  logic [DW-1:0] mem [1 << AW];
  always @(posedge clk) begin
    if (wr) mem[wr_add] <= in;
    if (rd) out <= mem[rd_add];
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard and protocol model, owned by the monitor process.
  logic [DW-1:0] sb[$];
  int            pop_cnt  = 0;
  int            push_cnt = 0;
  int            viol     = 0;
  int            cnt_m    = 0;
  int            infl_m   = 0;
  logic [AW-1:0] rptr_m   = '0;
  logic [AW-1:0] wptr_m   = '0;

  initial begin : monitor
    int            pop_m;
    logic [DW-1:0] exp_w;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        sb.delete();
        cnt_m  = 0;
        infl_m = 0;
        rptr_m = '0;
        wptr_m = '0;
      end else begin
        pop_m = (m_valid && m_ready) ? 1 : 0;
        if (pop_m == 1) begin
          pop_cnt++;
          if (sb.size() == 0) begin
            chk("pop_unexpected", m_data, 64'hx);
          end else begin
            exp_w = sb.pop_front();
            chk("pop_data", m_data, exp_w);
          end
        end
        if (m_valid !== (cnt_m != 0)) viol++;
        if (cnt_m > 2) viol++;
        if (rd) begin
          if (cnt_m + infl_m - pop_m >= 2) viol++;
          if (rd_add !== rptr_m) viol++;
          rptr_m++;
        end
        if (s_valid && s_ready) begin
          if (!wr || wr_add !== wptr_m || in !== s_data) viol++;
          sb.push_back(s_data);
          push_cnt++;
          wptr_m++;
        end else if (wr) begin
          viol++;
        end
        cnt_m  = cnt_m + infl_m - pop_m;
        infl_m = rd ? 1 : 0;
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while (!(empty && sb.size() == 0) && n < 20000) begin
      step();
      n++;
    end
    chk({name, "_drained"}, 64'(n < 20000), 64'd1);
    chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  localparam logic [63:0] Word1 = 64'hDEAD_BEEF_0000_0001;

  initial begin : stim
    int flag;
    int p0;
    int q0;
    resetn  = 1'b0;
    s_valid = 1'b1;
    s_data  = 64'hFFFF_0000_FFFF_0000;
    m_ready = 1'b0;

    // Reset: held for 3 clocks with s_valid high; nothing may leak to the RAM.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data",  m_data, 64'd0);
    chk("rst_empty",   64'(empty), 64'd1);
    chk("rst_full",    64'(full), 64'd0);
    chk("rst_wr",      64'(wr), 64'd0);
    chk("rst_rd",      64'(rd), 64'd0);
    chk("rst_in",      in, 64'd0);
    chk("rst_wr_add",  64'(wr_add), 64'd0);
    chk("rst_rd_add",  64'(rd_add), 64'd0);
    s_valid = 1'b0;
    resetn  = 1'b1;
    repeat (3) step();
    chk("idle_empty", 64'(empty), 64'd1);
    chk("idle_rd",    64'(rd), 64'd0);

    // Single word: push at edge T, rd at T+1, m_valid after T+2.
    s_valid = 1'b1;
    s_data  = Word1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("sw_wr",     64'(wr), 64'd1);
    chk("sw_wr_add", 64'(wr_add), 64'd0);
    chk("sw_in",     in, Word1);
    chk("sw_rd_pre", 64'(rd), 64'd0);
    step();
    s_valid = 1'b0;
    @(negedge clk);
    chk("sw_rd",      64'(rd), 64'd1);
    chk("sw_rd_add",  64'(rd_add), 64'd0);
    chk("sw_mv_t1",   64'(m_valid), 64'd0);
    step();
    @(negedge clk);
    chk("sw_mv_t2",   64'(m_valid), 64'd0);
    chk("sw_rd_t2",   64'(rd), 64'd0);
    step();
    @(negedge clk);
    chk("sw_mv_t3",   64'(m_valid), 64'd1);
    chk("sw_m_data",  m_data, Word1);
    step();
    @(negedge clk);
    chk("sw_empty",   64'(empty), 64'd1);
    chk("sw_mv_done", 64'(m_valid), 64'd0);
    step();

    // Fill: 4096 words with m_ready low; two move to the output buffer, so not full.
    m_ready = 1'b0;
    flag    = 0;
    p0      = pop_cnt;
    for (int i = 0; i < 4096; i++) begin
      s_valid = 1'b1;
      s_data  = {32'hF111_0000, 32'(i)};
      @(negedge clk);
      if (full || !s_ready) flag++;
      step();
    end
    s_valid = 1'b0;
    chk("fill_never_full", 64'(flag), 64'd0);
    repeat (3) step();
    @(negedge clk);
    chk("fill_4096_full",  64'(full), 64'd0);
    chk("fill_4096_mv",    64'(m_valid), 64'd1);
    chk("fill_4096_head",  m_data, {32'hF111_0000, 32'd0});
    step();
    for (int i = 4096; i < 4098; i++) begin
      s_valid = 1'b1;
      s_data  = {32'hF111_0000, 32'(i)};
      step();
    end
    @(negedge clk);
    chk("fill_full",    64'(full), 64'd1);
    chk("fill_s_ready", 64'(s_ready), 64'd0);
    chk("fill_no_wr",   64'(wr), 64'd0);
    step();
    s_valid = 1'b0;
    drain("fill");
    chk("fill_pop_count", 64'(pop_cnt - p0), 64'd4098);

    // Streaming: one push and one pop per cycle once the pipeline is primed.
    flag = 0;
    p0   = pop_cnt;
    m_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      s_valid = 1'b1;
      s_data  = 64'hA5A5_0000_0000_0000 | 64'(i);
      @(negedge clk);
      if (!s_ready) flag++;
      if (i >= 3 && !m_valid) flag++;
      step();
    end
    s_valid = 1'b0;
    chk("stream_no_gaps", 64'(flag), 64'd0);
    drain("stream");
    chk("stream_pop_count", 64'(pop_cnt - p0), 64'd10000);

    // Backpressure: ~30% pop acceptance against continuous push.
    p0 = pop_cnt;
    q0 = push_cnt;
    for (int i = 0; i < 2000; i++) begin
      s_valid = 1'b1;
      s_data  = {32'hBB00_0000, 32'(i)};
      m_ready = ($urandom_range(0, 99) < 30);
      step();
    end
    drain("bp");
    chk("bp_count_match", 64'(pop_cnt - p0), 64'(push_cnt - q0));

    // Mid-run reset with 100 words stored.
    m_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1;
      s_data  = {32'hCC00_0000, 32'(i)};
      step();
    end
    s_valid = 1'b0;
    step();
    chk("mr_pre_mv",    64'(m_valid), 64'd1);
    chk("mr_pre_empty", 64'(empty), 64'd0);
    #2;
    resetn = 1'b0;
    #1;
    chk("mr_m_valid", 64'(m_valid), 64'd0);
    chk("mr_m_data",  m_data, 64'd0);
    chk("mr_empty",   64'(empty), 64'd1);
    chk("mr_s_ready", 64'(s_ready), 64'd1);
    chk("mr_rd",      64'(rd), 64'd0);
    repeat (2) step();
    resetn = 1'b1;
    p0      = pop_cnt;
    m_ready = 1'b1;
    repeat (10) step();
    chk("mr_no_old_pop", 64'(pop_cnt - p0), 64'd0);
    chk("mr_empty_post", 64'(empty), 64'd1);
    s_valid = 1'b1;
    s_data  = 64'h0123_4567_89AB_CDEF;
    step();
    drain("mr_new");
    chk("mr_new_pop", 64'(pop_cnt - p0), 64'd1);

    repeat (2) step();
    chk("protocol_violations", 64'(viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
